// File: rtl/shiftrows_pipe.sv
// rtl/shiftrows_pipe.sv - pipelined ShiftRows/InvShiftRows stage with tag sideband and valid/ready flow control
module shiftrows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_inv,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [32*NB-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAG_W-1:0]             out_tag,
  output logic [32*NB-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int W     = 32 * NB;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Reject unsupported geometries at elaboration time.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("shiftrows_pipe: DEPTH must be >= 1");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shiftrows_pipe: TAG_W must be >= 1");
  end

  // Byte permutation: pure wiring, both directions built, in_inv picks one per byte.
  logic [W-1:0] perm;
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row offsets; 256-bit blocks use the wider 0/1/3/4 pattern.
      localparam int SR = (r == 0) ? 0 :
                          (r == 1) ? 1 :
                          (r == 2) ? ((NB == 8) ? 3 : 2) :
                                     ((NB == 8) ? 4 : 3);
      localparam int SF = (c + SR) % NB;
      localparam int SI = (c - SR + NB) % NB;
      assign perm[W-1-8*(c*4+r) -: 8] = in_inv ? in_data[W-1-8*(SI*4+r) -: 8]
                                               : in_data[W-1-8*(SF*4+r) -: 8];
    end
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   en;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [W-1:0]     data_q [DEPTH];

  // A stage may load when it is empty or everything downstream of it can move.
  // Written in closed form (any hole downstream, or sink ready) to avoid a comb chain on en.
  assign en[DEPTH] = out_ready;
  for (genvar k = 0; k < DEPTH; k++) begin : g_en
    assign en[k] = out_ready | ~(&v[DEPTH-1:k]);
  end

  assign in_ready = en[0] & ~flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             nxt_v;
    logic [TAG_W-1:0] nxt_tag;
    logic [W-1:0]     nxt_data;

    if (k == 0) begin : g_first
      assign nxt_v    = in_valid & in_ready;
      assign nxt_tag  = in_tag;
      assign nxt_data = perm;
    end else begin : g_next
      assign nxt_v    = v[k-1] & en[k-1];
      assign nxt_tag  = tag_q[k-1];
      assign nxt_data = data_q[k-1];
    end

    // Stage register: flush drops the valid bit only, payload moves whenever the stage is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[k]      <= 1'b0;
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end else begin
        if (flush) begin
          v[k] <= 1'b0;
        end else if (en[k]) begin
          v[k] <= nxt_v;
        end
        if (en[k]) begin
          tag_q[k]  <= nxt_tag;
          data_q[k] <= nxt_data;
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Occupancy is a popcount of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

endmodule

// File: doc/shiftrows_pipe.md
Name: shiftrows_pipe

Overview:
Parametrised, pipelined ShiftRows/InvShiftRows stage for the pipelined AES/Rijndael datapath. It supports Rijndael block widths of 4, 6 or 8 columns, and forward or inverse shift chosen per transaction. A tag sideband travels with each block. The stage uses a valid/ready elastic pipeline with full throughput and backpressure, and sits between the SubBytes and MixColumns stages of a round pipeline.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8 (block width 32*NB bits); any other value is an elaboration error.
DEPTH, 2, number of register stages (latency in cycles); must be >= 1.
TAG_W, 8, width of the sideband tag carried alongside each block; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input block valid.
in_ready  out  1  stage can accept an input block this cycle.
in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows; captured with the block.
in_tag  in  TAG_W  sideband tag, passed through unmodified.
in_data  in  32*NB  input state.
out_valid  out  1  output block valid.
out_ready  in  1  downstream accepts the output block.
out_tag  out  TAG_W  tag of the output block.
out_data  out  32*NB  shifted state.
occupancy  out  clog2(DEPTH+1)  number of valid stages in the pipeline.

Behaviour:
- Byte b[i] = data[32*NB-1-8*i -: 8], with b0 at the MSB. Column-major layout: b[c*4+r] is column c, row r.
- Row offsets s_r:
  - NB=4 or 6: s0=0, s1=1, s2=2, s3=3.
  - NB=8: s0=0, s1=1, s2=3, s3=4.
- Forward: out[c*4+r] = in[((c+s_r) mod NB)*4+r].
- Inverse: out[c*4+r] = in[((c-s_r+NB) mod NB)*4+r].
- The permutation is applied combinationally on in_data before stage 0 registers. Stages 1..DEPTH-1 carry data unchanged. in_inv affects only its own block.
- Per stage k: registers v[k], tag[k], data[k]. Define en[DEPTH] = out_ready and en[k] = !v[k] | en[k+1]. Stage k loads from stage k-1 (or from the input for k=0) when en[k] is high.
  - On load, v[0] <= in_valid & in_ready.
  - On load, v[k] <= v[k-1] & en[k-1] for k >= 1.
- in_ready = en[0] & !flush. The ready path is combinational from out_ready; this is accepted.
- out_valid = v[DEPTH-1]; out_data and out_tag come from the last stage registers.
- Latency is exactly DEPTH cycles with no stalls. Throughput is one block per cycle while out_ready is held high.
- A held output (out_valid=1, out_ready=0) keeps out_data and out_tag stable until accepted. No bubble is inserted when the stall releases.
- occupancy = popcount(v), registered-equivalent (derived from the v registers). Range 0..DEPTH.
- Full pipeline with out_ready=0: in_ready=0, and in_valid is ignored without being lost (the upstream source holds it).
- Simultaneous accept and emit when full: allowed, and occupancy is unchanged.
- flush=1: in_ready=0 that cycle, and all v[k] clear at the next edge regardless of out_ready. Data registers are not cleared. An output handshake in the flush cycle still completes for the sink.
- Reset (asynchronous, any time including mid-stream):
  - all v[k]=0, data and tag registers=0.
  - Outputs: out_valid=0, out_data=0, out_tag=0, occupancy=0.
  - in_ready=1 once rst_n is high and flush=0.

Test Plan:
1. NB=4, DEPTH=2, forward, in_data=d42711aee0bf98f1b8b45de51e415230, tag=0x5A -> out_data=d4bf5d30e0b452aeb84111f11e2798e5 with tag 0x5A, out_valid exactly 2 cycles after accept.
2. NB=4, inverse, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230. Then alternate in_inv on 8 back-to-back blocks -> each output matches its own mode and order is preserved.
3. NB=8, forward, b[i]=i (00..1f) -> column 0 of output = 00050e13, column 7 = 1c010a0f. Then inverse of that output -> original 00..1f.
4. Backpressure, DEPTH=3: stream 10 blocks with out_ready toggling pseudo-randomly -> no loss, no duplication, order kept, data stable while stalled. With out_ready=0 and 3 blocks held: occupancy=3 and in_ready=0.
5. flush with 2 blocks in flight and in_valid=1 -> in_ready=0 that cycle, occupancy=0 and out_valid=0 next cycle, and the flushed blocks never emerge.
6. rst_n asserted asynchronously mid-stream between clock edges -> out_valid, occupancy, out_data and out_tag go to 0 immediately. After release, the first new block emerges after DEPTH cycles.
